data_bus_slave: RTL and testbench

Responder on the far end of the core's data-memory port (ram_ce/we/addr/sel/data). It decodes each access into a byte-lane-writable data RAM or a small peripheral block: a free-running timer with compare interrupt and a console transmit FIFO. It sits in the SoC top next to the CPU core. Reads are answered combinationally in the same MEM-stage cycle and writes commit on the clock edge, so the core never stalls.

---
 rtl/data_bus_slave.sv | 211 +++++++++++++++++++++
 tb/tb_data_bus_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_slave.sv
// data_bus_slave
//
// Responder for the core's data-memory port. Each access is decoded into a
// byte-lane-writable data RAM, a timer/status register block, or a console
// transmit FIFO. Reads are combinational in the same cycle. Writes commit on
// the rising clock edge, so the core never has to stall.
//
// Address map (byte addresses, bits [1:0] are ignored for word selection):
//   0x0000_0000 .. RAM_WORDS*4-1  data RAM
//   0x1000_0000  COUNT    free-running up-counter, loadable
//   0x1000_0004  COMPARE  timer compare value
//   0x1000_0008  CTRL     bit0 en, bit1 irq_en
//   0x1000_000C  STATUS   bit0 MATCH (w1c), bit1 FULL, bit2 EMPTY, bit3 OVF (w1c)
//   0x1000_0010  CONSOLE  write pushes data[7:0]; reads as 0
//   anything else        unmapped: reads 0, writes ignored
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   ram_ce_i          access enable
//   ram_we_i          1 = write, 0 = read
//   ram_addr_i        byte address
//   ram_sel_i         byte-lane enables for writes
//   ram_data_i        write data
//   ram_data_o        combinational read data (0 when ram_ce_i is low)
//   timer_irq_o       level interrupt, MATCH & irq_en
//   con_valid_o       console FIFO holds a byte
//   con_data_o        byte at the FIFO head (0 when empty)
//   con_ready_i       console sink takes the head byte this cycle

module data_bus_slave #(
  parameter int RAM_WORDS  = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        timer_irq_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] REG_COUNT   = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic        hit_ram;
  logic        hit_regs;
  logic        hit_con;
  logic        bus_wr;
  logic [1:0]  reg_idx;
  logic [AW-1:0] ram_idx;
  logic [31:0] lane_mask;

  assign hit_ram  = (ram_addr_i[31:28] == 4'h0) &&
                    (ram_addr_i[29:2] < 28'(RAM_WORDS));
  assign hit_regs = (ram_addr_i[31:4] == 28'h1000_000);
  assign hit_con  = (ram_addr_i == 32'h1000_0010);
  assign bus_wr   = ram_ce_i & ram_we_i;
  assign reg_idx  = ram_addr_i[3:2];
  assign ram_idx  = ram_addr_i[2 +: AW];

  assign lane_mask = {{8{ram_sel_i[3]}}, {8{ram_sel_i[2]}},
                      {8{ram_sel_i[1]}}, {8{ram_sel_i[0]}}};

  logic wr_count;
  logic wr_compare;
  logic wr_ctrl;
  logic wr_status;

  assign wr_count   = bus_wr & hit_regs & (reg_idx == REG_COUNT);
  assign wr_compare = bus_wr & hit_regs & (reg_idx == REG_COMPARE);
  assign wr_ctrl    = bus_wr & hit_regs & (reg_idx == REG_CTRL) & ram_sel_i[0];
  assign wr_status  = bus_wr & hit_regs & (reg_idx == REG_STATUS) & ram_sel_i[0];

  // --------------------------------------------------------------------------
  // Data RAM: no reset, contents survive rst
  // --------------------------------------------------------------------------
  logic [31:0] ram_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (bus_wr && hit_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_sel_i[i]) ram_mem[ram_idx][8*i +: 8] <= ram_data_i[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Console FIFO
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  // --------------------------------------------------------------------------
  logic [FW:0]  wr_ptr;
  logic [FW:0]  rd_ptr;
  logic [7:0]   fifo_mem [FIFO_DEPTH];
  logic         fifo_empty;
  logic         fifo_full;
  logic         push_req;
  logic         push_ok;
  logic         pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) &&
                      (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);

  assign pop      = ~fifo_empty & con_ready_i;
  assign push_req = bus_wr & hit_con & ram_sel_i[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok  = push_req & (~fifo_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[FW-1:0]] <= ram_data_i[7:0];
  end

  assign con_valid_o = ~fifo_empty;
  assign con_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[FW-1:0]];

  // --------------------------------------------------------------------------
  // Timer and status registers
  // --------------------------------------------------------------------------
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        en_q;
  logic        irq_en_q;
  logic        match_q;
  logic        ovf_q;

  logic        match_set;
  logic        match_clr;
  logic        ovf_set;
  logic        ovf_clr;

  assign match_set = en_q && (count_q == compare_q);
  assign match_clr = wr_status & ram_data_i[0];
  assign ovf_set   = push_req & fifo_full & ~pop;
  assign ovf_clr   = wr_status & ram_data_i[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // A bus write replaces the increment for that cycle.
      if (wr_count)  count_q <= (count_q & ~lane_mask) | (ram_data_i & lane_mask);
      else if (en_q) count_q <= count_q + 32'd1;

      if (wr_compare)
        compare_q <= (compare_q & ~lane_mask) | (ram_data_i & lane_mask);

      if (wr_ctrl) begin
        en_q     <= ram_data_i[0];
        irq_en_q <= ram_data_i[1];
      end

      // Set has priority over a same-cycle write-1-to-clear.
      match_q <= match_set | (match_q & ~match_clr);
      ovf_q   <= ovf_set   | (ovf_q   & ~ovf_clr);
    end
  end

  assign timer_irq_o = match_q & irq_en_q;

  // --------------------------------------------------------------------------
  // Read mux. During a write cycle the pre-write contents are presented.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_data_o = 32'h0;
    if (ram_ce_i) begin
      if (hit_ram) begin
        ram_data_o = ram_mem[ram_idx];
      end else if (hit_regs) begin
        case (reg_idx)
          REG_COUNT:   ram_data_o = count_q;
          REG_COMPARE: ram_data_o = compare_q;
          REG_CTRL:    ram_data_o = {30'h0, irq_en_q, en_q};
          REG_STATUS:  ram_data_o = {28'h0, ovf_q, fifo_empty, fifo_full, match_q};
          default:     ram_data_o = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_bus_slave.sv
module tb_data_bus_slave;

  localparam logic [31:0] A_COUNT   = 32'h1000_0000;
  localparam logic [31:0] A_COMPARE = 32'h1000_0004;
  localparam logic [31:0] A_CTRL    = 32'h1000_0008;
  localparam logic [31:0] A_STATUS  = 32'h1000_000C;
  localparam logic [31:0] A_CON     = 32'h1000_0010;

  logic        clk;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        timer_irq_o;
  logic        con_valid_o;
  logic [7:0]  con_data_o;
  logic        con_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  data_bus_slave #(.RAM_WORDS(4096), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_ce_i    (ram_ce_i),
    .ram_we_i    (ram_we_i),
    .ram_addr_i  (ram_addr_i),
    .ram_sel_i   (ram_sel_i),
    .ram_data_i  (ram_data_i),
    .ram_data_o  (ram_data_o),
    .timer_irq_o (timer_irq_o),
    .con_valid_o (con_valid_o),
    .con_data_o  (con_data_o),
    .con_ready_i (con_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, commit on the rising edge, release 1ns later.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_addr_i = a; ram_data_i = d; ram_sel_i = s;
    @(posedge clk);
    #1;
    ram_ce_i = 1'b0; ram_we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = a; ram_sel_i = 4'h0;
    #1;
    d = ram_data_o;
    ram_ce_i = 1'b0;
  endtask

  logic [31:0] rd;
  logic [7:0]  exp_bytes [4];
  int          wait_n;

  initial begin
    rst = 1'b1; ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_addr_i = '0;
    ram_sel_i = '0; ram_data_i = '0; con_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_valid", con_valid_o, 0);
    check("rst_irq", timer_irq_o, 0);
    check("rst_con_data", con_data_o, 0);
    check("rst_data_o_ce0", ram_data_o, 0);
    bus_rd(A_COUNT, rd);  check("rst_count", rd, 32'h0);
    bus_rd(A_STATUS, rd); check("rst_status", rd, 32'h4);

    // RAM byte lanes
    bus_wr(32'h100, 32'h1122_3344, 4'b1111);
    bus_wr(32'h100, 32'hAABB_CCDD, 4'b0100);
    bus_rd(32'h100, rd); check("ram_lanes", rd, 32'h11BB_3344);

    // RAM boundary and unmapped aliasing
    bus_wr(32'h3FFC, 32'hDEAD_BEEF, 4'b1111);
    bus_rd(32'h3FFC, rd); check("ram_top_word", rd, 32'hDEAD_BEEF);
    bus_wr(32'h0, 32'hCAFE_F00D, 4'b1111);
    bus_wr(32'h4000, 32'h5555_5555, 4'b1111);
    bus_rd(32'h0, rd);    check("ram_no_alias", rd, 32'hCAFE_F00D);
    bus_rd(32'h4000, rd); check("unmapped_ram_end", rd, 32'h0);
    bus_rd(32'h2000_0000, rd); check("unmapped_2000", rd, 32'h0);
    bus_rd(32'h1000_0014, rd); check("unmapped_per_end", rd, 32'h0);

    // ce=0 with we=1: output 0 and no write
    @(negedge clk);
    ram_ce_i = 1'b0; ram_we_i = 1'b1; ram_addr_i = 32'h100; ram_data_i = 32'h0; ram_sel_i = 4'hF;
    #1;
    check("ce0_data_o", ram_data_o, 32'h0);
    @(posedge clk);
    #1;
    ram_we_i = 1'b0;
    bus_rd(32'h100, rd); check("ce0_no_write", rd, 32'h11BB_3344);

    // Register lane merge and CTRL read-back
    bus_wr(A_COUNT, 32'h1234_5678, 4'b1111);
    bus_wr(A_COUNT, 32'hAAAA_AAAA, 4'b0010);
    bus_rd(A_COUNT, rd); check("count_lane_merge", rd, 32'h1234_AA78);
    bus_wr(A_CTRL, 32'hFFFF_FFFE, 4'b1111);
    bus_rd(A_CTRL, rd);  check("ctrl_readback", rd, 32'h2);
    bus_wr(A_CTRL, 32'h0, 4'b1111);

    // Timer compare: MATCH on the 6th edge after the CTRL write edge
    bus_wr(A_COMPARE, 32'd5, 4'b1111);
    bus_wr(A_COUNT, 32'd0, 4'b1111);
    bus_wr(A_CTRL, 32'd3, 4'b1111);
    repeat (6) @(negedge clk);
    check("irq_before_match", timer_irq_o, 0);
    @(negedge clk);
    check("irq_at_match", timer_irq_o, 1);
    bus_rd(A_STATUS, rd); check("status_match", rd, 32'h5);
    bus_wr(A_STATUS, 32'h1, 4'b0001);
    check("irq_cleared", timer_irq_o, 0);

    // COUNT load while running
    bus_wr(A_COUNT, 32'h100, 4'b1111);
    bus_rd(A_COUNT, rd); check("count_load", rd, 32'h100);
    bus_rd(A_COUNT, rd); check("count_incr", rd, 32'h101);

    // Wrap
    bus_wr(A_COUNT, 32'hFFFF_FFFF, 4'b1111);
    bus_rd(A_COUNT, rd); check("count_max", rd, 32'hFFFF_FFFF);
    bus_rd(A_COUNT, rd); check("count_wrap", rd, 32'h0);
    bus_wr(A_CTRL, 32'h0, 4'b1111);
    bus_wr(A_STATUS, 32'h9, 4'b0001);

    // FIFO fill, overflow, drain
    bus_wr(A_CON, 32'h41, 4'b0001);
    bus_wr(A_CON, 32'h42, 4'b0001);
    bus_wr(A_CON, 32'h43, 4'b0001);
    bus_wr(A_CON, 32'h44, 4'b0001);
    bus_rd(A_STATUS, rd); check("fifo_full_status", rd, 32'h2);
    check("fifo_valid", con_valid_o, 1);
    bus_wr(A_CON, 32'h45, 4'b0001);
    bus_rd(A_STATUS, rd); check("fifo_ovf_status", rd, 32'hA);
    bus_rd(A_CON, rd);    check("console_reads_0", rd, 32'h0);
    exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43; exp_bytes[3] = 8'h44;
    @(negedge clk);
    con_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain1_byte%0d", i), con_data_o, exp_bytes[i]);
      @(negedge clk);
    end
    check("drain1_empty_valid", con_valid_o, 0);
    check("drain1_empty_data", con_data_o, 0);
    con_ready_i = 1'b0;
    bus_rd(A_STATUS, rd); check("status_empty_ovf", rd, 32'hC);
    bus_wr(A_STATUS, 32'h8, 4'b0001);
    bus_rd(A_STATUS, rd); check("status_ovf_cleared", rd, 32'h4);

    // Push into a full FIFO while popping: accepted, no overflow
    bus_wr(A_CON, 32'h01, 4'b0001);
    bus_wr(A_CON, 32'h02, 4'b0001);
    bus_wr(A_CON, 32'h03, 4'b0001);
    bus_wr(A_CON, 32'h04, 4'b0001);
    @(negedge clk);
    con_ready_i = 1'b1;
    ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_addr_i = A_CON; ram_data_i = 32'h05; ram_sel_i = 4'b0001;
    @(posedge clk);
    #1;
    ram_ce_i = 1'b0; ram_we_i = 1'b0; con_ready_i = 1'b0;
    bus_rd(A_STATUS, rd); check("simul_full_no_ovf", rd, 32'h2);
    exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h03; exp_bytes[2] = 8'h04; exp_bytes[3] = 8'h05;
    @(negedge clk);
    con_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain2_byte%0d", i), con_data_o, exp_bytes[i]);
      @(negedge clk);
    end
    check("drain2_empty_valid", con_valid_o, 0);
    con_ready_i = 1'b0;

    // Reset mid-stream
    bus_wr(A_COUNT, 32'd0, 4'b1111);
    bus_wr(A_COMPARE, 32'd2, 4'b1111);
    bus_wr(A_CTRL, 32'd3, 4'b1111);
    bus_wr(A_CON, 32'h5A, 4'b0001);
    wait_n = 0;
    while (!timer_irq_o && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("pre_rst_irq", timer_irq_o, 1);
    check("pre_rst_valid", con_valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_irq", timer_irq_o, 0);
    check("rst_async_valid", con_valid_o, 0);
    check("rst_async_data", con_data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(A_CTRL, rd);   check("post_rst_ctrl", rd, 32'h0);
    bus_rd(A_COUNT, rd);  check("post_rst_count", rd, 32'h0);
    bus_rd(A_STATUS, rd); check("post_rst_status", rd, 32'h4);
    bus_rd(32'h100, rd);  check("post_rst_ram_kept", rd, 32'h11BB_3344);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
